// File: rtl/yolo_class_vec_packer_pkg.sv
// ----------------------------------------------------------------------------
// Package: yolo_class_vec_packer_pkg
// Purpose: Shared constants and types for the YOLO class-score vector packer.
//          Describes how one anchor's 40 int8 class scores are split into
//          5 beats of 8 scores each.
// Contents:
//   SCORE_W      bits per class score (int8)
//   CLS_PER_GRP  scores carried by one 64-bit beat
//   NUM_GRP      beats per anchor vector (comparator bank is 5 lanes wide)
//   NUM_CLS      classes per anchor
//   BEAT_CNT_W   width of the beat counter (0..NUM_GRP-1)
//   COL_IDX_W    width of an index into the 4-entry collect buffer
// ----------------------------------------------------------------------------
package yolo_class_vec_packer_pkg;

    localparam int SCORE_W     = 8;
    localparam int CLS_PER_GRP = 8;
    localparam int NUM_GRP     = 5;
    localparam int NUM_CLS     = CLS_PER_GRP * NUM_GRP;
    localparam int BEAT_CNT_W  = $clog2(NUM_GRP);
    localparam int COL_IDX_W   = $clog2(NUM_GRP - 1);

    typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

    localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(NUM_GRP - 1);

endpackage

// File: rtl/yolo_class_vec_packer_if.sv
// ----------------------------------------------------------------------------
// Interface: yolo_class_vec_packer_if
// Purpose: Bundles the score-beat input stream and the packed anchor-vector
//          output stream of the class-vector packer.
// Signals:
//   s_data/s_valid/s_ready/s_last   64-bit score beat stream (8 x int8)
//   pc1..pc5                        packed anchor vector, classes 0-7..32-39
//   pc_valid/pc_ready               vector handshake
//   pc_anchor_id                    anchor index of presented vector
//   pc_last                         presented vector is the layer's last
// Modports:
//   slave   packer view (consumes beats, produces vectors)
//   master  environment view (produces beats, consumes vectors)
// ----------------------------------------------------------------------------
interface yolo_class_vec_packer_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
);

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              s_last;

    logic [DATA_W-1:0] pc1;
    logic [DATA_W-1:0] pc2;
    logic [DATA_W-1:0] pc3;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] pc5;
    logic              pc_valid;
    logic              pc_ready;
    logic [CNT_W-1:0]  pc_anchor_id;
    logic              pc_last;

    modport slave (
        input  s_data, s_valid, s_last, pc_ready,
        output s_ready, pc1, pc2, pc3, pc4, pc5, pc_valid, pc_anchor_id, pc_last
    );

    modport master (
        output s_data, s_valid, s_last, pc_ready,
        input  s_ready, pc1, pc2, pc3, pc4, pc5, pc_valid, pc_anchor_id, pc_last
    );

endinterface

// File: rtl/yolo_class_vec_packer.sv
// ----------------------------------------------------------------------------
// Module: yolo_class_vec_packer
// Purpose: Feeder for the 5-lane class-score comparator bank. Collects 5
//          consecutive 64-bit beats of int8 class scores (40 classes, one
//          anchor) and presents them as pc1..pc5 with a valid/ready handshake,
//          tagged with a per-layer anchor index and a last-of-layer flag.
// Ports:
//   clk                rising-edge clock
//   rst                synchronous active-high reset
//   yolo_layer_finish  synchronous clear of all packing state (rst wins)
//   bus (slave)        beat stream in, packed vector out (see interface)
//   layer_done         1-cycle pulse when the pc_last vector is taken
//   pack_err           sticky: s_last seen on a beat other than the 5th
// Notes:
//   The output is a single register slice. Beat 4 is only stalled when that
//   slice is full and not being drained, so drain+refill in one cycle keeps
//   the throughput at one vector per NUM_GRP beats.
//   NUM_GRP must stay 5: the output port set is fixed at pc1..pc5.
// ----------------------------------------------------------------------------
module yolo_class_vec_packer
    import yolo_class_vec_packer_pkg::*;
#(
    parameter int DATA_W  = SCORE_W * CLS_PER_GRP,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         yolo_layer_finish,
    yolo_class_vec_packer_if.slave       bus,
    output logic                         layer_done,
    output logic                         pack_err
);

    logic [DATA_W-1:0] r_collect [0:NUM_GRP-2];
    beat_cnt_t         r_beat_cnt;
    logic [DATA_W-1:0] r_pc_p1   [0:NUM_GRP-1];
    logic              r_vld_p1;
    logic              r_last_p1;
    logic [CNT_W-1:0]  r_anchor_id_p1;
    logic [CNT_W-1:0]  r_anchor_cnt;
    logic              r_layer_done;
    logic              r_pack_err;

    logic w_clr;
    logic w_last_beat;
    logic w_s_ready;
    logic w_s_fire;
    logic w_pc_fire;
    logic w_load;
    logic w_frame_err;
    logic w_layer_end;

    assign w_clr       = rst | yolo_layer_finish;
    assign w_last_beat = (r_beat_cnt == LAST_BEAT);
    // Only the closing beat can stall, and only if the held vector is not
    // leaving this cycle; nothing is accepted during a clear.
    assign w_s_ready   = !w_clr && !(w_last_beat && r_vld_p1 && !bus.pc_ready);
    assign w_s_fire    = bus.s_valid && w_s_ready;
    assign w_pc_fire   = r_vld_p1 && bus.pc_ready && !w_clr;
    assign w_load      = w_s_fire && w_last_beat;
    assign w_frame_err = w_s_fire && bus.s_last && !w_last_beat;
    assign w_layer_end = w_pc_fire && r_last_p1;

    // ---- Stage 0: beat collection ----
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_beat_cnt <= '0;
            for (int i = 0; i < NUM_GRP - 1; i++) begin
                r_collect[i] <= '0;
            end
        end else if (w_s_fire) begin
            // A closing beat or a premature s_last both restart the group;
            // the partial group is simply abandoned on a framing error.
            if (w_last_beat || bus.s_last) begin
                r_beat_cnt <= '0;
            end else begin
                r_collect[r_beat_cnt[COL_IDX_W-1:0]] <= bus.s_data;
                r_beat_cnt <= r_beat_cnt + beat_cnt_t'(1);
            end
        end
    end

    // ---- Stage 1: output holding slice ----
    always_ff @(posedge clk) begin
        if (w_clr) begin
            for (int i = 0; i < NUM_GRP; i++) begin
                r_pc_p1[i] <= '0;
            end
            r_vld_p1       <= 1'b0;
            r_last_p1      <= 1'b0;
            r_anchor_id_p1 <= '0;
        end else if (w_load) begin
            for (int i = 0; i < NUM_GRP - 1; i++) begin
                r_pc_p1[i] <= r_collect[i];
            end
            r_pc_p1[NUM_GRP-1] <= bus.s_data;
            r_vld_p1           <= 1'b1;
            r_last_p1          <= bus.s_last;
            r_anchor_id_p1     <= r_anchor_cnt;
        end else if (w_pc_fire) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
        end
    end

    // ---- Layer bookkeeping: anchor counter, done pulse, sticky error ----
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_anchor_cnt <= '0;
            r_layer_done <= 1'b0;
            r_pack_err   <= 1'b0;
        end else begin
            r_layer_done <= w_layer_end;
            if (w_frame_err) begin
                r_pack_err <= 1'b1;
            end
            // End of layer (good or broken) restarts numbering; this takes
            // precedence over an increment from a load in the same cycle.
            if (w_layer_end || w_frame_err) begin
                r_anchor_cnt <= '0;
            end else if (w_load) begin
                r_anchor_cnt <= r_anchor_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.s_ready      = w_s_ready;
    assign bus.pc1          = r_pc_p1[0];
    assign bus.pc2          = r_pc_p1[1];
    assign bus.pc3          = r_pc_p1[2];
    assign bus.pc4          = r_pc_p1[3];
    assign bus.pc5          = r_pc_p1[4];
    assign bus.pc_valid     = r_vld_p1;
    assign bus.pc_anchor_id = r_anchor_id_p1;
    assign bus.pc_last      = r_last_p1;
    assign layer_done       = r_layer_done;
    assign pack_err         = r_pack_err;

endmodule

// File: tb/tb_yolo_class_vec_packer.sv
// ----------------------------------------------------------------------------
// Testbench: tb_yolo_class_vec_packer
// Purpose: Directed, table-driven checks of the class-vector packer plus
//          hand-written back-pressure and throughput sequences.
// ----------------------------------------------------------------------------
module tb_yolo_class_vec_packer;

    logic clk;
    logic rst;
    logic fin;
    logic layer_done;
    logic pack_err;

    yolo_class_vec_packer_if #(.DATA_W(64), .CNT_W(16)) bus ();

    yolo_class_vec_packer #(.DATA_W(64), .CNT_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .yolo_layer_finish (fin),
        .bus               (bus),
        .layer_done        (layer_done),
        .pack_err          (pack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // chk: 0 = no check, 1 = control outputs, 2 = control plus pc1/pc5/id/last
    typedef struct {
        logic       rst;
        logic       fin;
        logic       sv;
        logic [7:0] sb;
        logic       sl;
        logic       pr;
        int         chk;
        logic       e_sready;
        logic       e_vld;
        logic [7:0] e_b1;
        logic [7:0] e_b5;
        logic [15:0] e_id;
        logic       e_last;
        logic       e_done;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [63:0] mk(input logic [7:0] b);
        return {8{b}};
    endfunction

    function automatic vec_t V(input logic r, input logic f, input logic sv,
                               input logic [7:0] sb, input logic sl, input logic pr,
                               input int chk, input logic esr, input logic ev,
                               input logic [7:0] eb1, input logic [7:0] eb5,
                               input logic [15:0] eid, input logic el,
                               input logic ed, input logic ee);
        vec_t v;
        v.rst = r; v.fin = f; v.sv = sv; v.sb = sb; v.sl = sl; v.pr = pr;
        v.chk = chk; v.e_sready = esr; v.e_vld = ev; v.e_b1 = eb1; v.e_b5 = eb5;
        v.e_id = eid; v.e_last = el; v.e_done = ed; v.e_err = ee;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic sv,
                         input logic [7:0] sb, input logic sl, input logic pr);
        rst          = r;
        fin          = f;
        bus.s_valid  = sv;
        bus.s_data   = mk(sb);
        bus.s_last   = sl;
        bus.pc_ready = pr;
    endtask

    // back-pressure sequence state
    int            beat;
    int            stall_cnt;
    int            stall_beat;
    int            unstable;
    int            got;
    int            hs_cyc [0:7];
    logic [15:0]   hs_id  [0:7];
    logic [63:0]   hs_pc1 [0:7];
    logic [63:0]   hs_pc5 [0:7];
    logic [63:0]   snap   [0:4];
    logic          prev_hold;

    initial begin
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // reset
        tbl.push_back(V(1,0,0,8'h00,0,0, 0, 0,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(1,0,0,8'h00,0,0, 0, 0,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(0,0,0,8'h00,0,1, 2, 1,0,8'h00,8'h00,16'd0,0,0,0));
        // single anchor with s_last on the 5th beat
        tbl.push_back(V(0,0,1,8'h01,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(0,0,1,8'h02,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(0,0,1,8'h03,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(0,0,1,8'h04,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(0,0,1,8'h05,1,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(0,0,0,8'h00,0,1, 2, 1,1,8'h01,8'h05,16'd0,1,0,0));
        tbl.push_back(V(0,0,0,8'h00,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,1,0));
        tbl.push_back(V(0,0,0,8'h00,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,0));
        // framing error: s_last on beat 2
        tbl.push_back(V(0,0,1,8'h11,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(0,0,1,8'h12,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(0,0,1,8'h13,1,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(0,0,0,8'h00,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,1));
        tbl.push_back(V(0,0,1,8'h21,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,1));
        tbl.push_back(V(0,0,1,8'h22,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,1));
        tbl.push_back(V(0,0,1,8'h23,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,1));
        tbl.push_back(V(0,0,1,8'h24,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,1));
        tbl.push_back(V(0,0,1,8'h25,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,1));
        tbl.push_back(V(0,0,0,8'h00,0,1, 2, 1,1,8'h21,8'h25,16'd0,0,0,1));
        // vector held with pc_ready=0, then clear after beat 3 of next anchor
        tbl.push_back(V(0,0,1,8'h31,0,0, 1, 1,0,8'h00,8'h00,16'd0,0,0,1));
        tbl.push_back(V(0,0,1,8'h32,0,0, 1, 1,0,8'h00,8'h00,16'd0,0,0,1));
        tbl.push_back(V(0,0,1,8'h33,0,0, 1, 1,0,8'h00,8'h00,16'd0,0,0,1));
        tbl.push_back(V(0,0,1,8'h34,0,0, 1, 1,0,8'h00,8'h00,16'd0,0,0,1));
        tbl.push_back(V(0,0,1,8'h35,0,0, 1, 1,0,8'h00,8'h00,16'd0,0,0,1));
        tbl.push_back(V(0,0,1,8'h41,0,0, 2, 1,1,8'h31,8'h35,16'd1,0,0,1));
        tbl.push_back(V(0,0,1,8'h42,0,0, 2, 1,1,8'h31,8'h35,16'd1,0,0,1));
        tbl.push_back(V(0,0,1,8'h43,0,0, 2, 1,1,8'h31,8'h35,16'd1,0,0,1));
        tbl.push_back(V(0,0,1,8'h44,0,0, 2, 1,1,8'h31,8'h35,16'd1,0,0,1));
        tbl.push_back(V(0,1,1,8'h45,0,1, 2, 0,1,8'h31,8'h35,16'd1,0,0,1));
        tbl.push_back(V(0,0,0,8'h00,0,1, 2, 1,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(0,0,1,8'h51,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(0,0,1,8'h52,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(0,0,1,8'h53,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(0,0,1,8'h54,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(0,0,1,8'h55,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(0,0,0,8'h00,0,1, 2, 1,1,8'h51,8'h55,16'd0,0,0,0));
        tbl.push_back(V(0,0,0,8'h00,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(0,1,0,8'h00,0,1, 0, 0,0,8'h00,8'h00,16'd0,0,0,0));
        tbl.push_back(V(0,0,0,8'h00,0,1, 1, 1,0,8'h00,8'h00,16'd0,0,0,0));

        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].rst, tbl[r].fin, tbl[r].sv, tbl[r].sb, tbl[r].sl, tbl[r].pr);
            @(negedge clk);
            if (tbl[r].chk != 0) begin
                check($sformatf("row%0d s_ready", r), 64'(bus.s_ready), 64'(tbl[r].e_sready));
                check($sformatf("row%0d pc_valid", r), 64'(bus.pc_valid), 64'(tbl[r].e_vld));
                check($sformatf("row%0d layer_done", r), 64'(layer_done), 64'(tbl[r].e_done));
                check($sformatf("row%0d pack_err", r), 64'(pack_err), 64'(tbl[r].e_err));
            end
            if (tbl[r].chk == 2) begin
                check($sformatf("row%0d pc1", r), bus.pc1, mk(tbl[r].e_b1));
                check($sformatf("row%0d pc5", r), bus.pc5, mk(tbl[r].e_b5));
                check($sformatf("row%0d pc_anchor_id", r), 64'(bus.pc_anchor_id), 64'(tbl[r].e_id));
                check($sformatf("row%0d pc_last", r), 64'(bus.pc_last), 64'(tbl[r].e_last));
            end
            @(posedge clk);
            #1;
        end

        // Back-pressure: 3 anchors back-to-back, consumer stalled 10 cycles.
        beat = 0; stall_cnt = 0; stall_beat = -1; unstable = 0; got = 0;
        prev_hold = 1'b0;
        for (int c = 0; c < 100 && got < 3; c++) begin
            drive(1'b0, 1'b0, (beat < 15), 8'((beat / 5) * 16 + (beat % 5) + 1), 1'b0, (c >= 10));
            @(negedge clk);
            if (bus.s_valid && !bus.s_ready) begin
                stall_cnt++;
                stall_beat = beat;
            end
            if (prev_hold && (bus.pc1 !== snap[0] || bus.pc2 !== snap[1] || bus.pc3 !== snap[2] ||
                              bus.pc4 !== snap[3] || bus.pc5 !== snap[4])) begin
                unstable++;
            end
            snap[0] = bus.pc1; snap[1] = bus.pc2; snap[2] = bus.pc3;
            snap[3] = bus.pc4; snap[4] = bus.pc5;
            prev_hold = bus.pc_valid && !bus.pc_ready;
            if (bus.pc_valid && bus.pc_ready) begin
                hs_id[got]  = bus.pc_anchor_id;
                hs_pc1[got] = bus.pc1;
                hs_pc5[got] = bus.pc5;
                got++;
            end
            if (bus.s_valid && bus.s_ready) beat++;
            @(posedge clk);
            #1;
        end
        check("bp stall count", 64'(stall_cnt), 64'd1);
        check("bp stalled beat index", 64'(stall_beat), 64'd9);
        check("bp held outputs changed", 64'(unstable), 64'd0);
        check("bp vectors received", 64'(got), 64'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp id[%0d]", k), 64'(hs_id[k]), 64'(k));
            check($sformatf("bp pc1[%0d]", k), hs_pc1[k], mk(8'(k * 16 + 1)));
            check($sformatf("bp pc5[%0d]", k), hs_pc5[k], mk(8'(k * 16 + 5)));
        end

        // Clear anchor numbering before the throughput run.
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        @(posedge clk);
        #1;

        // Throughput: 20 continuous beats, consumer always ready.
        beat = 0; got = 0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            drive(1'b0, 1'b0, (beat < 20), 8'(8'h60 + beat), 1'b0, 1'b1);
            @(negedge clk);
            if (bus.pc_valid && bus.pc_ready) begin
                hs_cyc[got] = c;
                hs_id[got]  = bus.pc_anchor_id;
                hs_pc1[got] = bus.pc1;
                got++;
            end
            if (bus.s_valid && bus.s_ready) beat++;
            @(posedge clk);
            #1;
        end
        check("tp vectors received", 64'(got), 64'd4);
        check("tp first vector latency", 64'(hs_cyc[0]), 64'd5);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("tp id[%0d]", k), 64'(hs_id[k]), 64'(k));
            check($sformatf("tp pc1[%0d]", k), hs_pc1[k], mk(8'(8'h60 + 5 * k)));
            if (k > 0) begin
                check($sformatf("tp spacing[%0d]", k), 64'(hs_cyc[k] - hs_cyc[k-1]), 64'd5);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
